// File: rtl/huff_freq_ctrl_if.sv
// huff_freq_ctrl_if: symbol-stream and frequency-report handshake bundle
interface huff_freq_ctrl_if #(
  parameter int SYM_BITS = 3,
  parameter int CNT_BITS = 8
);
  logic [SYM_BITS-1:0] sym_in;
  logic                sym_valid;
  logic                sym_last;
  logic                sym_ready;
  logic [SYM_BITS-1:0] freq_sym;
  logic [CNT_BITS-1:0] freq_cnt;
  logic                freq_valid;
  logic                freq_ready;
  modport master (
    output sym_in, sym_valid, sym_last, freq_ready,
    input  sym_ready, freq_sym, freq_cnt, freq_valid
  );
  modport slave (
    input  sym_in, sym_valid, sym_last, freq_ready,
    output sym_ready, freq_sym, freq_cnt, freq_valid
  );
endinterface

// File: rtl/huff_freq_ctrl.sv
// huff_freq_ctrl: per-block symbol frequency tally with ordered count dump
module huff_freq_ctrl #(
  parameter int SYM_BITS = 3,
  parameter int CNT_BITS = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            start,
  huff_freq_ctrl_if.slave bus,
  output logic            busy,
  output logic            done,
  output logic            sat_flag
);
  localparam int NUM_SYM = 2 ** SYM_BITS;
  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, DUMP, FIN} state_t;
  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q [NUM_SYM];
  logic [CNT_BITS-1:0] cnt_d [NUM_SYM];
  logic [SYM_BITS-1:0] idx_q, idx_d;
  logic                sat_q, sat_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE:  state_d = start ? CLEAR : IDLE;
      CLEAR: begin
        cnt_d   = '{default: '0};
        idx_d   = '0;
        sat_d   = 1'b0;
        state_d = COUNT;
      end
      COUNT: if (bus.sym_valid) begin
        if (&cnt_q[bus.sym_in]) sat_d = 1'b1;
        else cnt_d[bus.sym_in] = cnt_q[bus.sym_in] + 1'b1;
        state_d = bus.sym_last ? DUMP : COUNT;
      end
      DUMP: if (bus.freq_ready) begin
        idx_d   = idx_q + 1'b1;
        state_d = &idx_q ? FIN : DUMP;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '{default: '0};
      idx_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
    end
  end
  assign bus.sym_ready  = state_q == COUNT;
  assign bus.freq_valid = state_q == DUMP;
  assign bus.freq_sym   = idx_q;
  assign bus.freq_cnt   = cnt_q[idx_q];
  assign busy           = state_q != IDLE;
  assign done           = state_q == FIN;
  assign sat_flag       = sat_q;
endmodule

// File: tb/tb_huff_freq_ctrl.sv
// tb_huff_freq_ctrl: randomized blocks checked against a count-table model
module tb_huff_freq_ctrl;
  localparam int SYM_BITS = 3;
  localparam int CNT_BITS = 8;
  localparam int NUM_SYM  = 2 ** SYM_BITS;
  localparam int CNT_MAX  = 2 ** CNT_BITS - 1;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, sat_flag;
  int   n_chk = 0;
  int   n_pass = 0;
  huff_freq_ctrl_if #(.SYM_BITS(SYM_BITS), .CNT_BITS(CNT_BITS)) bus ();
  huff_freq_ctrl #(.SYM_BITS(SYM_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %0d want %0d", tag, act, exp);
  endtask
  task automatic run_block(input int syms[$], input int gap, input int stall, input bit noise);
    int  cnt [NUM_SYM];
    int  sent, k, idx, cyc, sym;
    bit  v, r, sat;
    foreach (cnt[i]) cnt[i] = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("clr_busy", busy, 1);
    chk("clr_rdy", bus.sym_ready, 0);
    @(posedge clk); #1;
    sent = 0;
    k = 0;
    while (sent < syms.size() && k < 5000) begin
      v = gap < 0 ? (k % 2 == 0) : ($urandom_range(99) >= gap);
      sym = v ? syms[sent] : int'($urandom_range(NUM_SYM - 1));
      bus.sym_valid = v;
      bus.sym_in = sym[SYM_BITS-1:0];
      bus.sym_last = v && sent == syms.size() - 1;
      start = noise && $urandom_range(3) == 0;
      sat = 1'b0;
      foreach (cnt[i]) if (cnt[i] > CNT_MAX) sat = 1'b1;
      @(negedge clk);
      chk("cnt_rdy", bus.sym_ready, 1);
      chk("cnt_fv", bus.freq_valid, 0);
      chk("cnt_done", done, 0);
      chk("cnt_sat", sat_flag, sat);
      @(posedge clk); #1;
      if (v) begin
        cnt[sym]++;
        sent++;
      end
      k++;
    end
    if (k >= 5000) chk("cnt_timeout", 1, 0);
    bus.sym_valid = 1'b0;
    bus.sym_last = 1'b0;
    sat = 1'b0;
    foreach (cnt[i]) if (cnt[i] > CNT_MAX) sat = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < NUM_SYM && cyc < 500) begin
      r = $urandom_range(99) >= stall;
      bus.freq_ready = r;
      start = noise && $urandom_range(3) == 0;
      @(negedge clk);
      chk("dmp_fv", bus.freq_valid, 1);
      chk("dmp_rdy", bus.sym_ready, 0);
      chk("dmp_sym", bus.freq_sym, idx);
      chk("dmp_cnt", bus.freq_cnt, cnt[idx] > CNT_MAX ? CNT_MAX : cnt[idx]);
      chk("dmp_sat", sat_flag, sat);
      chk("dmp_done", done, 0);
      @(posedge clk); #1;
      if (r) idx++;
      cyc++;
    end
    if (cyc >= 500) chk("dmp_timeout", 1, 0);
    bus.freq_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 1);
    chk("fin_fv", bus.freq_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask
  initial begin
    int q[$];
    bus.sym_in = '0;
    bus.sym_valid = 1'b0;
    bus.sym_last = 1'b0;
    bus.freq_ready = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_rdy", bus.sym_ready, 0);
    chk("rst_fv", bus.freq_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_sym", bus.freq_sym, 0);
    chk("rst_cnt", bus.freq_cnt, 0);
    chk("rst_sat", sat_flag, 0);
    #19 n_rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    bus.sym_valid = 1'b1;
    bus.sym_in = 3'd5;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.sym_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", bus.sym_ready, 0);
    chk("mid_rst_fv", bus.freq_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sym", bus.freq_sym, 0);
    chk("mid_rst_cnt", bus.freq_cnt, 0);
    chk("mid_rst_sat", sat_flag, 0);
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    q = '{1, 6};
    run_block(q, 0, 0, 1'b0);
    q = '{3, 3, 5, 0};
    run_block(q, 0, 0, 1'b0);
    run_block(q, 0, 50, 1'b0);
    q = {};
    repeat (300) q.push_back(2);
    run_block(q, 0, 0, 1'b0);
    q = '{7, 7, 1};
    run_block(q, -1, 0, 1'b1);
    q = '{4};
    run_block(q, 0, 0, 1'b0);
    repeat (6) begin
      q = {};
      repeat ($urandom_range(1, 40)) q.push_back(int'($urandom_range(NUM_SYM - 1)));
      run_block(q, 30, 40, 1'b1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
